wb_port_arbiter: RTL and testbench

//  Sequences the single register-file write port of the RV32I core between two requesters:
//  the execute path (E, ALU result) and the memory path (M, load return).

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_age_counter.sv | 33 +++
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 tb/tb_wb_port_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback port arbiter.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef enum logic {
        WB_SRC_M = 1'b0,
        WB_SRC_E = 1'b1
    } wb_src_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_M = 2'd1,
        WR_E = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_age_counter.sv
// Saturating count of consecutive cycles the execute requester has been refused.
module wb_age_counter
    import wb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    // MAX_WAIT = 0 would give a zero-width counter; keep one bit that never leaves 0
    localparam int CW = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == MAX_C);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between execute and load paths.
// Optional same-cycle bypass outputs are enabled with `define WB_FWD_EN.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              E_VALID,
    output logic              E_READY,
    input  logic [ADDR_W-1:0] E_RD,
    input  logic [DATA_W-1:0] E_DATA,
    input  logic              M_VALID,
    output logic              M_READY,
    input  logic [ADDR_W-1:0] M_RD,
    input  logic [DATA_W-1:0] M_DATA,
    output logic              RF_WE,
    output logic [ADDR_W-1:0] RF_WADDR,
    output logic [DATA_W-1:0] RF_WDATA,
`ifdef WB_FWD_EN
    output logic              FWD_VALID,
    output logic [ADDR_W-1:0] FWD_RD,
    output logic [DATA_W-1:0] FWD_DATA,
`endif
    output logic              CRT_WB
);

    wb_state_t         state_p1, state_nxt;
    wb_src_t           src_p1, src_p0;
    logic [ADDR_W-1:0] waddr_p1, waddr_p0;
    logic [DATA_W-1:0] wdata_p1, wdata_p0;
    logic              e_sat, m_win, m_xfer, e_xfer, wr_p0;

    wb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
        .clk  (CLK),
        .rst_n(RST_N),
        .inc  (E_VALID && !E_READY),
        .clr  (!E_VALID || e_xfer),
        .sat  (e_sat)
    );

    // Stage p0: grant and select the transfer for this cycle
    always_comb begin
        m_win    = M_VALID && !(E_VALID && e_sat);
        M_READY  = RST_N && m_win;
        E_READY  = RST_N && !m_win && E_VALID;
        m_xfer   = M_VALID && M_READY;
        e_xfer   = E_VALID && E_READY;
        src_p0   = m_xfer ? WB_SRC_M : WB_SRC_E;
        waddr_p0 = m_xfer ? M_RD : E_RD;
        wdata_p0 = m_xfer ? M_DATA : E_DATA;
        // x0 writes are accepted but never reach the register file
        wr_p0    = (m_xfer || e_xfer) && (waddr_p0 != '0);
    end

    always_comb begin
        state_nxt = IDLE;
        if (m_xfer && (M_RD != '0)) begin
            state_nxt = WR_M;
        end else if (e_xfer && (E_RD != '0)) begin
            state_nxt = WR_E;
        end
    end

    // Stage p1: registered write port
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_p1   <= WB_SRC_M;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else if (wr_p0) begin
            src_p1   <= src_p0;
            waddr_p1 <= waddr_p0;
            wdata_p1 <= wdata_p0;
        end
    end

    assign RF_WE    = (state_p1 != IDLE);
    assign RF_WADDR = waddr_p1;
    assign RF_WDATA = wdata_p1;
    assign CRT_WB   = (src_p1 == WB_SRC_E);

`ifdef WB_FWD_EN
    assign FWD_VALID = wr_p0;
    assign FWD_RD    = waddr_p0;
    assign FWD_DATA  = wdata_p0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (MAX_WAIT = 4).
module tb_wb_port_arbiter;

    logic        CLK, RST_N;
    logic        E_VALID, E_READY, M_VALID, M_READY;
    logic [4:0]  E_RD, M_RD, RF_WADDR;
    logic [31:0] E_DATA, M_DATA, RF_WDATA;
    logic        RF_WE, CRT_WB;
`ifdef WB_FWD_EN
    logic        FWD_VALID;
    logic [4:0]  FWD_RD;
    logic [31:0] FWD_DATA;
`endif

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .E_VALID(E_VALID), .E_READY(E_READY), .E_RD(E_RD), .E_DATA(E_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_RD(M_RD), .M_DATA(M_DATA),
        .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
`ifdef WB_FWD_EN
        .FWD_VALID(FWD_VALID), .FWD_RD(FWD_RD), .FWD_DATA(FWD_DATA),
`endif
        .CRT_WB(CRT_WB)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic test_reset();
        RST_N = 1'b0;
        E_VALID = 1'b1; E_RD = 5'd4; E_DATA = 32'h1111_2222;
        M_VALID = 1'b1; M_RD = 5'd6; M_DATA = 32'h3333_4444;
        @(posedge CLK); @(posedge CLK); #1;
        checks++; if (E_READY !== 1'b0) begin errors++; $display("FAIL rst_e_ready: got %0b expected 0", E_READY); end
        checks++; if (M_READY !== 1'b0) begin errors++; $display("FAIL rst_m_ready: got %0b expected 0", M_READY); end
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b expected 0", RF_WE); end
        checks++; if (RF_WADDR !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %0d expected 0", RF_WADDR); end
        checks++; if (RF_WDATA !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %0h expected 0", RF_WDATA); end
        checks++; if (CRT_WB !== 1'b0) begin errors++; $display("FAIL rst_crt: got %0b expected 0", CRT_WB); end
        @(negedge CLK);
        E_VALID = 1'b0; M_VALID = 1'b0;
        RST_N = 1'b1;
    endtask

    task automatic test_e_only();
        @(negedge CLK);
        E_VALID = 1'b1; E_RD = 5'd5; E_DATA = 32'hDEAD_BEEF;
        #1;
        checks++; if (E_READY !== 1'b1) begin errors++; $display("FAIL eonly_ready: got %0b expected 1", E_READY); end
        checks++; if (M_READY !== 1'b0) begin errors++; $display("FAIL eonly_m_ready: got %0b expected 0", M_READY); end
        @(posedge CLK); #1;
        E_VALID = 1'b0;
        checks++; if (RF_WE !== 1'b1) begin errors++; $display("FAIL eonly_we: got %0b expected 1", RF_WE); end
        checks++; if (RF_WADDR !== 5'd5) begin errors++; $display("FAIL eonly_waddr: got %0d expected 5", RF_WADDR); end
        checks++; if (RF_WDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL eonly_wdata: got %0h expected deadbeef", RF_WDATA); end
        checks++; if (CRT_WB !== 1'b1) begin errors++; $display("FAIL eonly_crt: got %0b expected 1", CRT_WB); end
        @(posedge CLK); #1;
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL idle_we: got %0b expected 0", RF_WE); end
        checks++; if (RF_WADDR !== 5'd5) begin errors++; $display("FAIL idle_waddr: got %0d expected 5", RF_WADDR); end
        checks++; if (RF_WDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_wdata: got %0h expected deadbeef", RF_WDATA); end
        checks++; if (CRT_WB !== 1'b1) begin errors++; $display("FAIL idle_crt: got %0b expected 1", CRT_WB); end
    endtask

    task automatic test_aging();
        logic       exp_m;
        logic [4:0] exp_addr;
        M_VALID = 1'b1; M_RD = 5'd3; M_DATA = 32'h0000_0033;
        E_VALID = 1'b1; E_RD = 5'd7; E_DATA = 32'h0000_0077;
        for (int c = 0; c < 6; c++) begin
            exp_m    = (c != 4);
            exp_addr = exp_m ? 5'd3 : 5'd7;
            @(negedge CLK); #1;
            checks++; if (M_READY !== exp_m) begin errors++; $display("FAIL age_m_ready[%0d]: got %0b expected %0b", c, M_READY, exp_m); end
            checks++; if (E_READY !== !exp_m) begin errors++; $display("FAIL age_e_ready[%0d]: got %0b expected %0b", c, E_READY, !exp_m); end
            @(posedge CLK); #1;
            checks++; if (RF_WADDR !== exp_addr) begin errors++; $display("FAIL age_waddr[%0d]: got %0d expected %0d", c, RF_WADDR, exp_addr); end
            checks++; if (CRT_WB !== !exp_m) begin errors++; $display("FAIL age_crt[%0d]: got %0b expected %0b", c, CRT_WB, !exp_m); end
        end
        M_VALID = 1'b0; E_VALID = 1'b0;
    endtask

    task automatic test_x0_write();
        @(negedge CLK);
        E_VALID = 1'b1; E_RD = 5'd7; E_DATA = 32'h0000_0777;
        @(posedge CLK); #1;
        E_VALID = 1'b0;
        @(negedge CLK);
        M_VALID = 1'b1; M_RD = 5'd0; M_DATA = 32'h0000_1234;
        #1;
        checks++; if (M_READY !== 1'b1) begin errors++; $display("FAIL x0_m_ready: got %0b expected 1", M_READY); end
        @(posedge CLK); #1;
        M_VALID = 1'b0;
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL x0_we: got %0b expected 0", RF_WE); end
        checks++; if (CRT_WB !== 1'b1) begin errors++; $display("FAIL x0_crt: got %0b expected 1", CRT_WB); end
        checks++; if (RF_WADDR !== 5'd7) begin errors++; $display("FAIL x0_waddr: got %0d expected 7", RF_WADDR); end
    endtask

    task automatic test_reset_inflight();
        @(negedge CLK);
        E_VALID = 1'b1; E_RD = 5'd12; E_DATA = 32'h5555_AAAA;
        #1;
        checks++; if (E_READY !== 1'b1) begin errors++; $display("FAIL rif_e_ready: got %0b expected 1", E_READY); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (E_READY !== 1'b0) begin errors++; $display("FAIL rif_e_ready_rst: got %0b expected 0", E_READY); end
        checks++; if (CRT_WB !== 1'b0) begin errors++; $display("FAIL rif_crt_async: got %0b expected 0", CRT_WB); end
        @(posedge CLK); #1;
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL rif_we: got %0b expected 0", RF_WE); end
        checks++; if (RF_WADDR !== 5'd0) begin errors++; $display("FAIL rif_waddr: got %0d expected 0", RF_WADDR); end
        checks++; if (RF_WDATA !== 32'd0) begin errors++; $display("FAIL rif_wdata: got %0h expected 0", RF_WDATA); end
        @(negedge CLK);
        E_VALID = 1'b0;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL rif_we_after: got %0b expected 0", RF_WE); end
    endtask

    task automatic test_forward();
        @(negedge CLK);
        M_VALID = 1'b1; M_RD = 5'd9; M_DATA = 32'h0000_CAFE;
        #1;
        checks++; if (M_READY !== 1'b1) begin errors++; $display("FAIL fwd_m_ready: got %0b expected 1", M_READY); end
`ifdef WB_FWD_EN
        checks++; if (FWD_VALID !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %0b expected 1", FWD_VALID); end
        checks++; if (FWD_RD !== 5'd9) begin errors++; $display("FAIL fwd_rd: got %0d expected 9", FWD_RD); end
        checks++; if (FWD_DATA !== 32'h0000_CAFE) begin errors++; $display("FAIL fwd_data: got %0h expected cafe", FWD_DATA); end
`endif
        @(posedge CLK); #1;
        M_VALID = 1'b0;
        checks++; if (RF_WE !== 1'b1) begin errors++; $display("FAIL fwd_we: got %0b expected 1", RF_WE); end
        checks++; if (RF_WADDR !== 5'd9) begin errors++; $display("FAIL fwd_waddr: got %0d expected 9", RF_WADDR); end
        checks++; if (RF_WDATA !== 32'h0000_CAFE) begin errors++; $display("FAIL fwd_wdata: got %0h expected cafe", RF_WDATA); end
        checks++; if (CRT_WB !== 1'b0) begin errors++; $display("FAIL fwd_crt: got %0b expected 0", CRT_WB); end
`ifdef WB_FWD_EN
        checks++; if (FWD_VALID !== 1'b0) begin errors++; $display("FAIL fwd_valid_idle: got %0b expected 0", FWD_VALID); end
`endif
    endtask

    initial begin
        RST_N = 1'b1;
        E_VALID = 1'b0; E_RD = '0; E_DATA = '0;
        M_VALID = 1'b0; M_RD = '0; M_DATA = '0;
        #2;
        test_reset();
        test_e_only();
        test_aging();
        test_x0_write();
        test_reset_inflight();
        test_forward();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
